// File: rtl/mips_pkg.sv
// Shared MIPS instruction-format definitions: field bit positions and the
// packed R-type view of a 32-bit instruction word.
package mips_pkg;

    localparam int OP_MSB    = 31;
    localparam int OP_LSB    = 26;
    localparam int RS_MSB    = 25;
    localparam int RS_LSB    = 21;
    localparam int RT_MSB    = 20;
    localparam int RT_LSB    = 16;
    localparam int RD_MSB    = 15;
    localparam int RD_LSB    = 11;
    localparam int SHAMT_MSB = 10;
    localparam int SHAMT_LSB = 6;
    localparam int FUNCT_MSB = 5;
    localparam int FUNCT_LSB = 0;
    localparam int IMM_MSB   = 15;
    localparam int IMM_LSB   = 0;
    localparam int TGT_MSB   = 25;
    localparam int TGT_LSB   = 0;

    typedef struct packed {
        logic [5:0] opCode;
        logic [4:0] Rs;
        logic [4:0] Rt;
        logic [4:0] Rd;
        logic [4:0] shamt;
        logic [5:0] func;
    } instr_t;

endpackage

// File: rtl/instr_decode_fields.sv
// Combinational split of a 32-bit MIPS word into its R/I/J-format fields.
module instr_decode_fields
    import mips_pkg::*;
(
    input  logic [31:0] word,
    output logic [5:0]  opCode,
    output logic [4:0]  Rs,
    output logic [4:0]  Rt,
    output logic [4:0]  Rd,
    output logic [4:0]  shamt,
    output logic [5:0]  func,
    output logic [15:0] addr,
    output logic [25:0] longAddr
);

    instr_t f;

    assign f        = instr_t'(word);
    assign opCode   = f.opCode;
    assign Rs       = f.Rs;
    assign Rt       = f.Rt;
    assign Rd       = f.Rd;
    assign shamt    = f.shamt;
    assign func     = f.func;
    assign addr     = word[IMM_MSB:IMM_LSB];
    assign longAddr = word[TGT_MSB:TGT_LSB];

endmodule

// File: rtl/instr_queue.sv
// DEPTH-entry instruction queue with PC, presenting the head pre-split into
// MIPS fields. Optional same-cycle empty-queue bypass under IR_BYPASS_EN.
module instr_queue #(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [31:0]      wr_inst,
    input  logic [PC_W-1:0]  wr_pc,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [31:0]      inst,
    output logic [PC_W-1:0]  pc,
    output logic [5:0]       opCode,
    output logic [4:0]       Rs,
    output logic [4:0]       Rt,
    output logic [4:0]       Rd,
    output logic [4:0]       shamt,
    output logic [5:0]       func,
    output logic [15:0]      addr,
    output logic [25:0]      longAddr,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [31:0]      mem_inst [DEPTH];
    logic [PC_W-1:0]  mem_pc   [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             stored_valid, bypass, push, pop;

    // Explicit wrap so non-power-of-two depths stay inside the buffer.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign wr_ready     = (cnt < CNT_W'(DEPTH));
    assign stored_valid = (cnt != '0);

`ifdef IR_BYPASS_EN
    assign bypass = (cnt == '0) & wr_valid & ~flush;
`else
    assign bypass = 1'b0;
`endif

    assign rd_valid = stored_valid | bypass;
    // A bypassed word taken by the consumer is never written into storage.
    assign push     = wr_valid & wr_ready & ~(bypass & rd_ready);
    assign pop      = stored_valid & rd_ready;
    assign count    = cnt;

    assign inst = bypass       ? wr_inst :
                  stored_valid ? mem_inst[rd_ptr] : '0;
    assign pc   = bypass       ? wr_pc :
                  stored_valid ? mem_pc[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            cnt    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= ptr_next(wr_ptr);
            if (pop)  rd_ptr <= ptr_next(rd_ptr);
            if (push && !pop)      cnt <= cnt + 1'b1;
            else if (pop && !push) cnt <= cnt - 1'b1;
        end
    end

    // Storage is intentionally unreset; the output gating hides stale data.
    always_ff @(posedge clk) begin
        if (rst_n && !flush && push) begin
            mem_inst[wr_ptr] <= wr_inst;
            mem_pc[wr_ptr]   <= wr_pc;
        end
    end

    instr_decode_fields u_dec (
        .word     (inst),
        .opCode   (opCode),
        .Rs       (Rs),
        .Rt       (Rt),
        .Rd       (Rd),
        .shamt    (shamt),
        .func     (func),
        .addr     (addr),
        .longAddr (longAddr)
    );

endmodule

// File: tb/tb_instr_queue.sv
// Directed bench for instr_queue: a vector table plus hand-written multi-cycle
// sequences, on a DEPTH=4 instance and a DEPTH=3 instance for wrap coverage.
module tb_instr_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    always #5 clk = ~clk;

    // DEPTH=4 instance
    logic        flush, wr_valid, wr_ready, rd_valid, rd_ready;
    logic [31:0] wr_inst, wr_pc, inst, pc;
    logic [5:0]  opCode, func;
    logic [4:0]  Rs, Rt, Rd, shamt;
    logic [15:0] addr;
    logic [25:0] longAddr;
    logic [2:0]  count;

    // DEPTH=3 instance
    logic        flush3, wr_valid3, wr_ready3, rd_valid3, rd_ready3;
    logic [31:0] wr_inst3, wr_pc3, inst3, pc3;
    logic [5:0]  opCode3, func3;
    logic [4:0]  Rs3, Rt3, Rd3, shamt3;
    logic [15:0] addr3;
    logic [25:0] longAddr3;
    logic [1:0]  count3;

    int n_cmp = 0;
    int n_bad = 0;

    instr_queue #(.DEPTH(4), .PC_W(32)) u_dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_inst(wr_inst), .wr_pc(wr_pc),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .inst(inst), .pc(pc),
        .opCode(opCode), .Rs(Rs), .Rt(Rt), .Rd(Rd), .shamt(shamt), .func(func),
        .addr(addr), .longAddr(longAddr), .count(count)
    );

    instr_queue #(.DEPTH(3), .PC_W(32)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .flush(flush3),
        .wr_valid(wr_valid3), .wr_ready(wr_ready3), .wr_inst(wr_inst3), .wr_pc(wr_pc3),
        .rd_valid(rd_valid3), .rd_ready(rd_ready3), .inst(inst3), .pc(pc3),
        .opCode(opCode3), .Rs(Rs3), .Rt(Rt3), .Rd(Rd3), .shamt(shamt3), .func(func3),
        .addr(addr3), .longAddr(longAddr3), .count(count3)
    );

    typedef struct {
        logic        flush;
        logic        wv;
        logic [31:0] winst;
        logic [31:0] wpc;
        logic        rr;
        logic        e_rv;
        logic        e_wr;
        logic [2:0]  e_cnt;
        logic [31:0] e_inst;
        logic [31:0] e_pc;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush    = 1'b0;
        wr_valid = 1'b0;
        rd_ready = 1'b0;
    endtask

    task automatic push4(input logic [31:0] w, input logic [31:0] p);
        wr_valid = 1'b1; wr_inst = w; wr_pc = p; rd_ready = 1'b0;
        cyc();
        idle();
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        idle();
        wr_inst = '0; wr_pc = '0;
        flush3 = 1'b0; wr_valid3 = 1'b0; rd_ready3 = 1'b0; wr_inst3 = '0; wr_pc3 = '0;

        tbl[0] = '{1'b0, 1'b1, 32'h012A4020, 32'h00400000, 1'b0, 1'b1, 1'b1, 3'd1, 32'h012A4020, 32'h00400000};
        tbl[1] = '{1'b0, 1'b1, 32'h8D090004, 32'h00400004, 1'b0, 1'b1, 1'b1, 3'd2, 32'h012A4020, 32'h00400000};
        tbl[2] = '{1'b0, 1'b1, 32'h3C011001, 32'h00400008, 1'b0, 1'b1, 1'b1, 3'd3, 32'h012A4020, 32'h00400000};
        tbl[3] = '{1'b0, 1'b1, 32'hAD280008, 32'h0040000C, 1'b0, 1'b1, 1'b0, 3'd4, 32'h012A4020, 32'h00400000};
        tbl[4] = '{1'b0, 1'b1, 32'h11111111, 32'h00400010, 1'b0, 1'b1, 1'b0, 3'd4, 32'h012A4020, 32'h00400000};
        tbl[5] = '{1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 1'b1, 1'b1, 3'd3, 32'h8D090004, 32'h00400004};
        tbl[6] = '{1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 1'b1, 1'b1, 3'd2, 32'h3C011001, 32'h00400008};
        tbl[7] = '{1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 1'b1, 1'b1, 3'd1, 32'hAD280008, 32'h0040000C};
        tbl[8] = '{1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 1'b0, 1'b1, 3'd0, 32'h0,        32'h0};

        repeat (2) cyc();
        rst_n = 1'b1;
        #1;
        chk("reset count",    32'(count), 32'd0);
        chk("reset rd_valid", 32'(rd_valid), 32'd0);
        chk("reset wr_ready", 32'(wr_ready), 32'd1);
        chk("reset inst",     inst, 32'h0);
        chk("reset pc",       pc, 32'h0);

        // Vector table: inputs held for one edge, outputs checked once idle.
        for (int i = 0; i < 9; i++) begin
            flush = tbl[i].flush; wr_valid = tbl[i].wv; wr_inst = tbl[i].winst;
            wr_pc = tbl[i].wpc; rd_ready = tbl[i].rr;
            cyc();
            idle();
            #1;
            chk($sformatf("v%0d rd_valid", i), 32'(rd_valid), 32'(tbl[i].e_rv));
            chk($sformatf("v%0d wr_ready", i), 32'(wr_ready), 32'(tbl[i].e_wr));
            chk($sformatf("v%0d count", i),    32'(count), 32'(tbl[i].e_cnt));
            chk($sformatf("v%0d inst", i),     inst, tbl[i].e_inst);
            chk($sformatf("v%0d pc", i),       pc, tbl[i].e_pc);
            if (i == 0) begin
                chk("add opCode",   32'(opCode), 32'd0);
                chk("add Rs",       32'(Rs), 32'd9);
                chk("add Rt",       32'(Rt), 32'd10);
                chk("add Rd",       32'(Rd), 32'd8);
                chk("add shamt",    32'(shamt), 32'd0);
                chk("add func",     32'(func), 32'h20);
                chk("add addr",     32'(addr), 32'h4020);
                chk("add longAddr", 32'(longAddr), 32'h012A4020);
            end
        end

        // Full queue: a same-cycle pop must not admit the offered write.
        for (int k = 0; k < 4; k++) push4(32'hC0000000 + k, 32'h100 + 4 * k);
        chk("full count", 32'(count), 32'd4);
        wr_valid = 1'b1; wr_inst = 32'hDEAD0000; wr_pc = 32'h1FC; rd_ready = 1'b1;
        #1;
        chk("full wr_ready during pop", 32'(wr_ready), 32'd0);
        cyc();
        idle();
        #1;
        chk("full+pop count", 32'(count), 32'd3);
        for (int k = 1; k < 4; k++) begin
            chk($sformatf("drain head %0d", k), inst, 32'hC0000000 + k);
            rd_ready = 1'b1;
            cyc();
            idle();
            #1;
        end
        chk("drain count", 32'(count), 32'd0);

        // Simultaneous push+pop at count 2 for 10 cycles.
        push4(32'h20000000, 32'h200);
        push4(32'h20000001, 32'h204);
        for (int k = 0; k < 10; k++) begin
            wr_valid = 1'b1; wr_inst = 32'h30000000 + k; wr_pc = 32'h300 + 4 * k; rd_ready = 1'b1;
            #1;
            chk($sformatf("pp head %0d", k), inst,
                (k == 0) ? 32'h20000000 : (k == 1) ? 32'h20000001 : 32'h30000000 + k - 2);
            cyc();
            idle();
            #1;
            chk($sformatf("pp count %0d", k), 32'(count), 32'd2);
        end
        chk("pp pc after wrap", pc, 32'h300 + 4 * 8);

        // Flush at count 3 with a push and pop offered.
        push4(32'h40000000, 32'h400);
        chk("pre-flush count", 32'(count), 32'd3);
        flush = 1'b1; wr_valid = 1'b1; wr_inst = 32'h50000000; wr_pc = 32'h500; rd_ready = 1'b1;
        cyc();
        idle();
        #1;
        chk("flush count",    32'(count), 32'd0);
        chk("flush rd_valid", 32'(rd_valid), 32'd0);
        chk("flush inst",     inst, 32'h0);
        chk("flush pc",       pc, 32'h0);
        chk("flush Rs",       32'(Rs), 32'd0);
        chk("flush wr_ready", 32'(wr_ready), 32'd1);
        cyc();
        chk("flush word lost", 32'(count), 32'd0);

        // Reset mid-stream at count 2.
        push4(32'h60000000, 32'h600);
        push4(32'h60000001, 32'h604);
        chk("pre-reset count", 32'(count), 32'd2);
        rst_n = 1'b0; wr_valid = 1'b1; wr_inst = 32'h70000000;
        cyc();
        rst_n = 1'b1;
        idle();
        #1;
        chk("rst count",    32'(count), 32'd0);
        chk("rst wr_ready", 32'(wr_ready), 32'd1);
        chk("rst inst",     inst, 32'h0);
        chk("rst rd_valid", 32'(rd_valid), 32'd0);

        // Empty queue offered a j with the consumer ready.
        wr_valid = 1'b1; wr_inst = 32'h08100000; wr_pc = 32'h800; rd_ready = 1'b1;
        #1;
`ifdef IR_BYPASS_EN
        chk("byp rd_valid", 32'(rd_valid), 32'd1);
        chk("byp opCode",   32'(opCode), 32'd2);
        chk("byp longAddr", 32'(longAddr), 32'h0100000);
        chk("byp pc",       pc, 32'h800);
        cyc();
        idle();
        #1;
        chk("byp count", 32'(count), 32'd0);
        chk("byp rd_valid after", 32'(rd_valid), 32'd0);
        wr_valid = 1'b1; wr_inst = 32'h08100001; rd_ready = 1'b0;
        #1;
        chk("byp hold inst", inst, 32'h08100001);
        cyc();
        idle();
        #1;
        chk("byp hold count", 32'(count), 32'd1);
        chk("byp hold stored", inst, 32'h08100001);
        rd_ready = 1'b1;
        cyc();
        idle();
        flush = 1'b1; wr_valid = 1'b1;
        #1;
        chk("byp flush rd_valid", 32'(rd_valid), 32'd0);
        cyc();
        idle();
        #1;
`else
        chk("nobyp rd_valid", 32'(rd_valid), 32'd0);
        chk("nobyp inst",     inst, 32'h0);
        cyc();
        idle();
        #1;
        chk("nobyp count",    32'(count), 32'd1);
        chk("nobyp opCode",   32'(opCode), 32'd2);
        chk("nobyp longAddr", 32'(longAddr), 32'h0100000);
        rd_ready = 1'b1;
        cyc();
        idle();
        #1;
`endif
        chk("final count", 32'(count), 32'd0);

        // DEPTH=3: push+pop for 10 cycles forces several pointer wraps.
        for (int k = 0; k < 2; k++) begin
            wr_valid3 = 1'b1; wr_inst3 = 32'hA0000000 + k; wr_pc3 = 32'hA00 + 4 * k;
            cyc();
        end
        wr_valid3 = 1'b0;
        #1;
        chk("d3 count", 32'(count3), 32'd2);
        for (int k = 0; k < 10; k++) begin
            wr_valid3 = 1'b1; wr_inst3 = 32'hB0000000 + k; wr_pc3 = 32'hB00 + 4 * k; rd_ready3 = 1'b1;
            #1;
            chk($sformatf("d3 head %0d", k), inst3,
                (k < 2) ? 32'hA0000000 + k : 32'hB0000000 + k - 2);
            cyc();
            wr_valid3 = 1'b0; rd_ready3 = 1'b0;
            #1;
            chk($sformatf("d3 count %0d", k), 32'(count3), 32'd2);
        end
        chk("d3 wr_ready", 32'(wr_ready3), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/instr_queue.md
# instr_queue

Parametrised successor to the multicycle instruction register: a DEPTH-entry instruction queue that captures fetched words with their PC through a valid/ready handshake. It presents the head entry already split into MIPS fields. It sits between the memory-data path and the control/register-file stage. It lets fetch run ahead of execute and lets the control FSM discard prefetched words on a branch or jump.

## Interface
- DEPTH, 4, number of entries; legal range 2..16, any integer, not restricted to powers of two
- PC_W, 32, width of the PC stored with each instruction
- CNT_W, $clog2(DEPTH+1), width of `count`
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- flush  in  1  discard all entries at the next edge
- wr_valid  in  1  fetch offers a word
- wr_ready  out  1  queue accepts; equals (count < DEPTH)
- wr_inst  in  32  fetched instruction word
- wr_pc  in  PC_W  address of wr_inst
- rd_valid  out  1  head entry valid
- rd_ready  in  1  consumer takes head (IRWrite-equivalent)
- inst  out  32  head instruction
- pc  out  PC_W  head PC
- opCode  out  6  inst[31:26]
- Rs  out  5  inst[25:21]
- Rt  out  5  inst[20:16]
- Rd  out  5  inst[15:11]
- shamt  out  5  inst[10:6]
- func  out  6  inst[5:0]
- addr  out  16  inst[15:0]
- longAddr  out  26  inst[25:0]
- count  out  CNT_W  occupied entries

## Operation
- Push = wr_valid & wr_ready. Pop = rd_valid & rd_ready.
- Storage is a circular buffer with wr_ptr and rd_ptr. Each pointer wraps from DEPTH-1 to 0 by explicit compare, not by bit overflow.
- Occupancy updates:
  - push only: count+1
  - pop only: count-1
  - push and pop together: count unchanged; both pointers advance
- Full (count==DEPTH): wr_ready=0. A pop in the same cycle does not free the slot for that cycle's write.
- Empty: rd_valid=0. All field outputs, inst and pc are driven 0. rd_ready is ignored.
- flush=1: at the edge, count, wr_ptr and rd_ptr all go to 0. Any push or pop in that cycle is discarded. wr_ready is unaffected by flush.
- Storage contents are not reset. Output gating makes stale entries unobservable.

## Timing
- Reset (rst_n=0 at an edge): count=0, pointers=0, rd_valid=0, wr_ready=1, all data outputs 0 from the next cycle.
- rst_n has priority over flush; flush has priority over push and pop.
- Write-to-read latency without bypass is 1 cycle: a word pushed at edge N is visible at the outputs after edge N.
- wr_ready depends only on registered count, never on rd_ready.
- Field outputs are combinational slices of the registered head, with no added latency.

## Configuration
- IR_BYPASS_EN defined:
  - When count==0 and wr_valid=1, rd_valid=1 in the same cycle and the outputs show wr_inst/wr_pc combinationally.
  - If rd_ready=1 in that cycle, the word is consumed and never stored: count stays 0 and pointers do not move.
  - If rd_ready=0, the word is stored normally.
  - During flush the bypass is suppressed: rd_valid=0.
- IR_BYPASS_EN undefined: the queue is strictly registered, with the 1-cycle latency given under Timing.

## Structure
- Shared package `mips_pkg`:
  - field bit-position localparams (OP_MSB/LSB, RS_, RT_, RD_, SHAMT_, FUNCT_, IMM_, TGT_)
  - `instr_t` packed struct {opCode, Rs, Rt, Rd, shamt, func}
- One sub-module `instr_decode_fields`: a combinational split of a 32-bit word into the field outputs. It is instantiated once on the head mux output.

## Test plan
- Reset, then push 0x012A4020 (add $t0,$t1,$t2) @ pc 0x0040_0000 with rd_ready=0. Next cycle: rd_valid=1, opCode=0, Rs=9, Rt=10, Rd=8, shamt=0, func=0x20, count=1.
- Push 4 words with rd_ready=0 (DEPTH=4). After the 4th: wr_ready=0, count=4. A 5th offer is not accepted. Popping all 4 returns them in order.
- At count=2, assert push and pop together for 10 cycles. Count stays 2, order is preserved, and pointers wrap cleanly (also run with DEPTH=3).
- At count=3 with push active, assert flush. Next cycle: count=0, rd_valid=0, outputs 0, and the pushed word is lost.
- Assert rst_n=0 mid-stream at count=2. Next cycle: count=0, wr_ready=1, inst=0.
- With IR_BYPASS_EN, queue empty, wr_valid=1 with 0x08100000 (j) and rd_ready=1. Same cycle: rd_valid=1, opCode=2, longAddr=0x0100000. Next cycle: count=0.
